// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and the signed-overflow helper for alu_multicycle
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // sb is the sign of the effective B operand (already inverted for SUB)
  function automatic logic sign_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shared shift-add multiply / restoring divide datapath
// nxt_hi/nxt_lo show the registers after the current step, so the top can capture the final step directly.
module alu_iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             step,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi,
  output logic             last
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             mode_q, mode_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  assign last = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Remainder stays below the divisor, so the shifted value always fits in WIDTH+1 bits
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    if (mode_q) begin
      nxt_hi = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd_q}) : rem_sh[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], rem_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = mode_div ? op_a : op_b;
      opnd_d = mode_div ? op_b : op_a;
      mode_d = mode_div;
      cnt_d  = '0;
    end else if (step) begin
      hi_d  = nxt_hi;
      lo_d  = nxt_lo;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - WIDTH-bit EX-stage ALU with registered results and iterative MULTU/DIVU
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic             md_load, md_step, md_last;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [WIDTH-1:0] add_res, sub_res, sc_lo;
  logic             add_ovf, sub_ovf, sc_ovf;
  logic [SHW-1:0]   shamt;

  alu_iter_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .mode_div (op == OP_DIVU),
    .op_a     (a),
    .op_b     (b),
    .step     (md_step),
    .nxt_lo   (md_lo),
    .nxt_hi   (md_hi),
    .last     (md_last)
  );

  always_comb begin
    shamt   = b[SHW-1:0];
    add_res = a + b;
    sub_res = a - b;
    add_ovf = sign_ovf(a[WIDTH-1], b[WIDTH-1], add_res[WIDTH-1]);
    sub_ovf = sign_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_res[WIDTH-1]);
    sc_lo   = '0;
    sc_ovf  = 1'b0;
    case (op)
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_ADD: begin
        sc_lo  = add_res;
        sc_ovf = add_ovf;
      end
      OP_SUB: begin
        sc_lo  = sub_res;
        sc_ovf = sub_ovf;
      end
      OP_SLT: sc_lo = {{(WIDTH-1){1'b0}}, sub_res[WIDTH-1] ^ sub_ovf};
      OP_SLL: sc_lo = a << shamt;
      OP_SRL: sc_lo = a >> shamt;
      OP_SRA: sc_lo = $unsigned($signed(a) >>> shamt);
      default: sc_lo = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    md_load  = 1'b0;
    md_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULTU || (op == OP_DIVU && b != '0)) begin
            md_load = 1'b1;
            state_d = S_RUN;
          end else if (op == OP_DIVU) begin
            res_lo_d = '1;
            res_hi_d = a;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            dbz_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            res_lo_d = sc_lo;
            res_hi_d = '0;
            zero_d   = (sc_lo == '0);
            ovf_d    = sc_ovf;
            dbz_d    = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        md_step = 1'b1;
        if (md_last) begin
          res_lo_d = md_lo;
          res_hi_d = md_hi;
          zero_d   = (md_lo == '0);
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      res_lo_q <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed scoreboard bench for alu_multicycle (WIDTH=32)
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         v;
    logic         d;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, overflow, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    e.lo = '0; e.hi = '0; e.v = 1'b0; e.d = 1'b0; e.lat = 1;
    case (o)
      OP_AND: e.lo = x & y;
      OP_OR:  e.lo = x | y;
      OP_ADD: begin
        e.lo = x + y;
        e.v  = (x[W-1] == y[W-1]) && (e.lo[W-1] != x[W-1]);
      end
      OP_SUB: begin
        e.lo = x - y;
        e.v  = (x[W-1] != y[W-1]) && (e.lo[W-1] != x[W-1]);
      end
      OP_SLT: e.lo = ($signed(x) < $signed(y)) ? 1 : 0;
      OP_SLL: e.lo = x << y[4:0];
      OP_SRL: e.lo = x >> y[4:0];
      OP_SRA: e.lo = $unsigned($signed(x) >>> y[4:0]);
      OP_MULTU: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 1;
      end
      OP_DIVU: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x; e.d = 1'b1;
        end else begin
          e.lo = x / y; e.hi = x % y; e.lat = W + 1;
        end
      end
      default: e.lo = '0;
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int inject_at);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
      end
      if (lat == inject_at) begin
        start = 1'b1; op = OP_ADD; a = 1; b = 1;
      end else if (lat == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) got = 1;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, " latency"}, 64'(lat), 64'(e.lat));
      chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
      chk({tag, " result_lo"}, 64'(result_lo), 64'(e.lo));
      chk({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
      chk({tag, " zero"}, 64'(zero), 64'(e.z));
      chk({tag, " overflow"}, 64'(overflow), 64'(e.v));
      chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.d));
      @(negedge clk);
      chk({tag, " done_pulse_end"}, 64'({done, busy}), 64'd0);
      chk({tag, " result_hold"}, 64'(result_lo), 64'(e.lo));
    end
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b1; op = OP_ADD; a = 1; b = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result_lo", 64'(result_lo), 64'd0);
    chk("reset result_hi", 64'(result_hi), 64'd0);
    rst = 1'b0; start = 1'b0;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("reset no_pulse", 64'(dn), 64'd0);

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 0);
    run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 0);
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_ovf", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'h24, 0);
    run_op("srl", OP_SRL, 32'h8000_0000, 32'h24, 0);
    run_op("sll", OP_SLL, 32'd1, 32'd31, 0);
    run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op("or", OP_OR, 32'hF000_0001, 32'h0000_1230, 0);
    run_op("illegal_op", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
    run_op("multu_zero", OP_MULTU, 32'd0, 32'h1234_5678, 0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    for (int i = 0; i < 3; i++) begin
      run_op("multu_rand", OP_MULTU, $urandom, $urandom, 0);
      run_op("divu_rand", OP_DIVU, $urandom, $urandom_range(1, 32'hFFFF), 0);
    end
    run_op("divu_by_zero", OP_DIVU, 32'd100, 32'd0, 0);

    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result_lo", 64'(result_lo), 64'd0);
    chk("abort result_hi", 64'(result_hi), 64'd0);
    chk("abort flags", 64'({zero, overflow, div_by_zero}), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort no_done", 64'(dn), 64'd0);
    run_op("add_after_abort", OP_ADD, 32'd2, 32'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
